// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control words and sequencer state encoding for the MUL helper.
package alu_mul_seq_pkg;

    // Hack ALU control bits, ordered {zx,nx,zy,ny,f,no}
    localparam logic [5:0] ALU_ADD   = 6'b000010;  // x + y
    localparam logic [5:0] ALU_XPASS = 6'b001010;  // x + 0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ALU.sv
// Hack ALU: combinational 16-bit ALU driven by six control bits.
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    // Operand zero/negate, function select, output negate and flags
    always_comb begin
        x_z   = zx ? '0 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? '0 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[15];
    end

endmodule

// File: rtl/Mux16.sv
// 16-bit two-way multiplexer: out = sel ? b : a.
module Mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);

    // Word select
    always_comb begin
        out = sel ? b : a;
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier sequencing a single Hack ALU.
// Each multiplier bit costs an ADD cycle (acc += mcand or acc += 0) and,
// except for the last bit, a DBL cycle (mcand += mcand, mplier >>= 1).
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned N_BITS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);

    localparam logic [3:0] LAST = 4'(N_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] acc, mcand, mplier;
    logic [3:0]  cnt;

    logic [5:0]  ctl;
    logic        xsel, ysel;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zr, alu_ng;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ALU steering for the current step
    always_comb begin
        state_d = state_q;
        ctl     = ALU_ADD;
        xsel    = 1'b0;
        ysel    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = ADD;
            end
            ADD: begin
                ysel    = 1'b1;
                ctl     = mplier[0] ? ALU_ADD : ALU_XPASS;
                state_d = (cnt == LAST) ? DONE : DBL;
            end
            DBL: begin
                xsel    = 1'b1;
                ysel    = 1'b1;
                state_d = ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // x selects acc (ADD) or mcand (DBL); y is mcand while sequencing, zero otherwise
    Mux16 u_xmux (
        .a   (acc),
        .b   (mcand),
        .sel (xsel),
        .out (alu_x)
    );

    Mux16 u_ymux (
        .a   (16'h0000),
        .b   (mcand),
        .sel (ysel),
        .out (alu_y)
    );

    ALU u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (ctl[5]),
        .nx  (ctl[4]),
        .zy  (ctl[3]),
        .ny  (ctl[2]),
        .f   (ctl[1]),
        .no  (ctl[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Datapath registers and registered handshake/result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            zr      <= 1'b0;
            ng      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                ADD: begin
                    acc <= alu_out;
                    if (cnt == LAST) begin
                        product <= alu_out;
                        zr      <= alu_zr;
                        ng      <= alu_ng;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                DONE: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq (default 16-bit and a 4-bit build).
module tb_alu_mul_seq;

    logic        clock;
    logic        reset_n;
    logic        start, start4;
    logic [15:0] a, b, a4, b4;
    logic        busy, done, zr, ng;
    logic        busy4, done4, zr4, ng4;
    logic [15:0] product, product4;

    int checks = 0;
    int errors = 0;

    alu_mul_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    alu_mul_seq #(.N_BITS(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4),
        .zr      (zr4),
        .ng      (ng4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: start pulse sampled at edge T0, done expected after edge T0+31
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic [15:0] exp_p, input logic exp_zr, input logic exp_ng,
                          input string tag);
        @(negedge clock);
        a = op_a; b = op_b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".busy_rise"}, {15'b0, busy}, 16'd1);
        repeat (30) @(negedge clock);
        check({tag, ".done_early"}, {15'b0, done}, 16'd0);
        check({tag, ".busy_hold"}, {15'b0, busy}, 16'd1);
        @(negedge clock);
        check({tag, ".done"}, {15'b0, done}, 16'd1);
        check({tag, ".busy_fall"}, {15'b0, busy}, 16'd0);
        check({tag, ".product"}, product, exp_p);
        check({tag, ".zr"}, {15'b0, zr}, {15'b0, exp_zr});
        check({tag, ".ng"}, {15'b0, ng}, {15'b0, exp_ng});
        @(negedge clock);
        check({tag, ".done_pulse"}, {15'b0, done}, 16'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clock);
        check("rst.busy", {15'b0, busy}, 16'd0);
        check("rst.done", {15'b0, done}, 16'd0);
        check("rst.product", product, 16'h0000);
        check("rst.zr", {15'b0, zr}, 16'd0);
        check("rst.ng", {15'b0, ng}, 16'd0);
        reset_n = 1'b1;

        run_op(16'd3,    16'd5,    16'h000F, 1'b0, 1'b0, "m3x5");
        run_op(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b1, "mff");
        run_op(16'hFFFD, 16'd7,    16'hFFEB, 1'b0, 1'b1, "mneg");
        run_op(16'h1234, 16'd0,    16'h0000, 1'b1, 1'b0, "mzero");
        run_op(16'h8000, 16'd2,    16'h0000, 1'b1, 1'b0, "mwrap");

        // Starts while busy and during DONE are ignored; held start is taken once back in IDLE
        @(negedge clock);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        a = 16'd9; b = 16'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ign.busy", {15'b0, busy}, 16'd1);
        repeat (26) @(negedge clock);
        check("ign.done", {15'b0, done}, 16'd1);
        check("ign.product", product, 16'h000F);
        start = 1'b1;
        @(negedge clock);
        check("ign.no_second_done", {15'b0, done}, 16'd0);
        check("ign.idle_busy", {15'b0, busy}, 16'd0);
        @(negedge clock);
        start = 1'b0;
        check("hold.accept", {15'b0, busy}, 16'd1);
        repeat (30) @(negedge clock);
        check("hold.done_early", {15'b0, done}, 16'd0);
        @(negedge clock);
        check("hold.done", {15'b0, done}, 16'd1);
        check("hold.product", product, 16'h0051);

        // Asynchronous reset mid-operation clears outputs without waiting for an edge
        @(negedge clock);
        a = 16'd7; b = 16'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst.busy", {15'b0, busy}, 16'd0);
        check("arst.done", {15'b0, done}, 16'd0);
        check("arst.product", product, 16'h0000);
        check("arst.ng", {15'b0, ng}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(16'd6, 16'd7, 16'h002A, 1'b0, 1'b0, "after_rst");

        // 4-bit build: only b[3:0] matters, done after edge T0+7
        @(negedge clock);
        a4 = 16'h0011; b4 = 16'h00F3; start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        check("n4.busy", {15'b0, busy4}, 16'd1);
        repeat (6) @(negedge clock);
        check("n4.done_early", {15'b0, done4}, 16'd0);
        @(negedge clock);
        check("n4.done", {15'b0, done4}, 16'd1);
        check("n4.busy_fall", {15'b0, busy4}, 16'd0);
        check("n4.product", product4, 16'h0033);
        check("n4.zr", {15'b0, zr4}, 16'd0);
        check("n4.ng", {15'b0, ng4}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
